matrix_entry: RTL and testbench

Front-end input sequencer for `matrixops`: turns a raw, bouncy push-button plus two 2-bit switch groups into clean, single-cycle `enter` strobes with stable `X`/`Y` operands. It also tracks which matrix element is being loaded. It sits directly upstream of `matrixops`, and its `enter`, `X` and `Y` outputs connect port-for-port to that block's inputs.

---
 rtl/matrix_pkg.sv | 15 +
 rtl/btn_debounce.sv | 81 ++++++++
 rtl/matrix_entry.sv | 71 +++++++
 tb/tb_matrix_entry.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix entry front end and matrixops.
package matrix_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESS   = 2'd1,
      FIRE    = 2'd2,
      RELEASE = 2'd3
   } db_state_e;

   typedef logic [1:0] elem_t;

   localparam int N_ELEM_DEF = 8;

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer and debounce FSM.
// Emits a one-cycle press pulse on the clock edge that enters FIRE.
module btn_debounce
   import matrix_pkg::*;
#(
   parameter int DB_CYCLES = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic press_o
);

   localparam int CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             sync1_q;
   logic             btn_s_q;
   db_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         btn_s_q <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         btn_s_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The transition edge counts as a sample, so DB_CYCLES-1 is the last count held.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (btn_s_q) begin
               state_d = PRESS;
               cnt_d   = CNT_W'(1);
            end
         end
         PRESS: begin
            if (!btn_s_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = FIRE;
               cnt_d   = '0;
               press_o = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FIRE: begin
            state_d = RELEASE;
            cnt_d   = '0;
         end
         RELEASE: begin
            if (btn_s_q) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/matrix_entry.sv
// Input sequencer for matrixops: debounced enter strobe, captured X/Y operands,
// and the index of the next matrix element to be loaded.
module matrix_entry
   import matrix_pkg::*;
#(
   parameter int DB_CYCLES = 4,
   parameter int N_ELEM    = N_ELEM_DEF,
   parameter int IDX_W     = $clog2(N_ELEM)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn,
   input  logic [1:0]       sw_x,
   input  logic [1:0]       sw_y,
   output logic             enter,
   output logic [1:0]       X,
   output logic [1:0]       Y,
   output logic [IDX_W-1:0] idx,
   output logic             done
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);

   logic             press;
   logic             enter_q;
   logic             done_q;
   elem_t            x_q, y_q;
   logic [IDX_W-1:0] idx_q, idx_d;

   btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
   ) u_debounce (
      .clk_i  (clk),
      .rst_i  (rst),
      .btn_i  (btn),
      .press_o(press)
   );

   // idx advances on the edge leaving FIRE, which is the edge ending the strobe.
   always_comb begin
      idx_d = idx_q;
      if (enter_q) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         enter_q <= 1'b0;
         done_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         idx_q   <= '0;
      end else begin
         enter_q <= press;
         done_q  <= press && (idx_q == IDX_LAST);
         idx_q   <= idx_d;
         if (press) begin
            x_q <= sw_x;
            y_q <= sw_y;
         end
      end
   end

   assign enter = enter_q;
   assign done  = done_q;
   assign X     = x_q;
   assign Y     = y_q;
   assign idx   = idx_q;

endmodule

// File: tb/tb_matrix_entry.sv
// Directed testbench for matrix_entry with DB_CYCLES=4, N_ELEM=8.
module tb_matrix_entry;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn;
   logic [1:0] sw_x;
   logic [1:0] sw_y;
   logic       enter;
   logic [1:0] X;
   logic [1:0] Y;
   logic [2:0] idx;
   logic       done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   matrix_entry #(
      .DB_CYCLES(4),
      .N_ELEM   (8)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn),
      .sw_x (sw_x),
      .sw_y (sw_y),
      .enter(enter),
      .X    (X),
      .Y    (Y),
      .idx  (idx),
      .done (done)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Clean press: hold 8 cycles, release 12 cycles, record what was strobed.
   task automatic do_press(input logic [1:0] x, input logic [1:0] y,
                           output int ne, output logic [1:0] gx, output logic [1:0] gy,
                           output logic gd, output int nd);
      ne = 0; nd = 0; gx = 2'bxx; gy = 2'bxx; gd = 1'bx;
      sw_x = x; sw_y = y; btn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 8) btn = 1'b0;
         tick();
         if (enter) begin
            ne++;
            gx = X; gy = Y; gd = done;
         end
         if (done) nd++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; btn = 1'b0; sw_x = 2'd0; sw_y = 2'd0;
      tick(); tick();
      checks++;
      if ({enter, done, X, Y, idx} !== 9'd0) begin
         errors++;
         $display("FAIL reset_state got=%b exp=%b", {enter, done, X, Y, idx}, 9'd0);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if ({enter, done, X, Y, idx} !== 9'd0) begin
            errors++;
            $display("FAIL idle_after_reset cyc=%0d got=%b exp=%b", i, {enter, done, X, Y, idx}, 9'd0);
         end
      end
   endtask

   task automatic test_single_press;
      int ne, first;
      logic [1:0] gx, gy;
      ne = 0; first = -1; gx = 2'bxx; gy = 2'bxx;
      sw_x = 2'd2; sw_y = 2'd3; btn = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         if (i == 21) btn = 1'b0;
         tick();
         if (enter) begin
            ne++;
            if (first < 0) first = i;
            gx = X; gy = Y;
         end
      end
      checks++;
      if (ne !== 1) begin errors++; $display("FAIL single_count got=%0d exp=1", ne); end
      checks++;
      if (first !== 6) begin errors++; $display("FAIL single_latency got=%0d exp=6", first); end
      checks++;
      if (gx !== 2'd2) begin errors++; $display("FAIL single_X got=%0d exp=2", gx); end
      checks++;
      if (gy !== 2'd3) begin errors++; $display("FAIL single_Y got=%0d exp=3", gy); end
      checks++;
      if (idx !== 3'd1) begin errors++; $display("FAIL single_idx got=%0d exp=1", idx); end
   endtask

   task automatic test_bounce;
      logic [4:0] pat;
      int ne;
      pat = 5'b01101;
      ne = 0;
      for (int i = 0; i < 5; i++) begin
         btn = pat[i];
         tick();
         if (enter) ne++;
      end
      btn = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (enter) ne++;
      end
      checks++;
      if (ne !== 0) begin errors++; $display("FAIL bounce_strobes got=%0d exp=0", ne); end
      checks++;
      if (idx !== 3'd1) begin errors++; $display("FAIL bounce_idx got=%0d exp=1", idx); end
   endtask

   task automatic test_eight_presses;
      logic [1:0] xs [8];
      logic [1:0] ys [8];
      int ne, nd;
      logic [1:0] gx, gy;
      logic gd;
      xs = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
      ys = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd3};
      rst = 1'b1; tick(); rst = 1'b0; tick();
      checks++;
      if (idx !== 3'd0) begin errors++; $display("FAIL seq_start_idx got=%0d exp=0", idx); end
      for (int i = 0; i < 8; i++) begin
         do_press(xs[i], ys[i], ne, gx, gy, gd, nd);
         checks++;
         if (ne !== 1) begin errors++; $display("FAIL seq_count el=%0d got=%0d exp=1", i, ne); end
         checks++;
         if ({gx, gy} !== {xs[i], ys[i]}) begin
            errors++;
            $display("FAIL seq_xy el=%0d got=%0d,%0d exp=%0d,%0d", i, gx, gy, xs[i], ys[i]);
         end
         checks++;
         if (gd !== (i == 7)) begin errors++; $display("FAIL seq_done_at_enter el=%0d got=%b exp=%b", i, gd, (i == 7)); end
         checks++;
         if (nd !== ((i == 7) ? 1 : 0)) begin errors++; $display("FAIL seq_done_count el=%0d got=%0d", i, nd); end
         checks++;
         if (idx !== 3'((i + 1) % 8)) begin errors++; $display("FAIL seq_idx el=%0d got=%0d exp=%0d", i, idx, (i + 1) % 8); end
      end
   endtask

   task automatic test_hold_switches;
      int ne, nd;
      logic [1:0] gx, gy;
      logic gd;
      sw_x = 2'd1; sw_y = 2'd1; btn = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      sw_x = 2'd0; sw_y = 2'd0; btn = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if ({X, Y} !== 4'b0101) begin
            errors++;
            $display("FAIL hold_xy cyc=%0d got=%0d,%0d exp=1,1", i, X, Y);
         end
      end
      do_press(2'd0, 2'd0, ne, gx, gy, gd, nd);
      checks++;
      if (ne !== 1) begin errors++; $display("FAIL hold_next_count got=%0d exp=1", ne); end
      checks++;
      if ({X, Y} !== 4'b0000) begin errors++; $display("FAIL hold_next_xy got=%0d,%0d exp=0,0", X, Y); end
      checks++;
      if (idx !== 3'd2) begin errors++; $display("FAIL hold_idx got=%0d exp=2", idx); end
   endtask

   task automatic test_reset_at_fire;
      int ne, first;
      btn = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (enter !== 1'b0) begin errors++; $display("FAIL rstfire_pre_enter got=%b exp=0", enter); end
      rst = 1'b1;
      tick();
      checks++;
      if ({enter, done, idx} !== 5'd0) begin
         errors++;
         $display("FAIL rstfire_dropped got=%b exp=%b", {enter, done, idx}, 5'd0);
      end
      rst = 1'b0;
      ne = 0; first = -1;
      for (int i = 1; i <= 14; i++) begin
         tick();
         if (enter) begin
            ne++;
            if (first < 0) first = i;
         end
      end
      checks++;
      if (ne !== 1) begin errors++; $display("FAIL rstfire_count got=%0d exp=1", ne); end
      checks++;
      if (first !== 6) begin errors++; $display("FAIL rstfire_latency got=%0d exp=6", first); end
      btn = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      checks++;
      if (idx !== 3'd1) begin errors++; $display("FAIL rstfire_idx got=%0d exp=1", idx); end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_eight_presses();
      test_hold_switches();
      test_reset_at_fire();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
